instr_fetch_unit: RTL and testbench

- Upstream neighbour of the immediate generator in the RISC-V core.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
- Latches each returned word into an instruction register, then presents it (plus `opcode`) to decode/ImmGen with a valid/ready handshake.
- Accepts branch redirects (target computed downstream from PC + ImmExt) and discards stale fetches.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/instr_fetch_unit_pc_next_sel.sv | 26 ++
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 tb/tb_instr_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes, NOP encoding, fetch-state encoding.
package riscv_pkg;
    localparam int XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return a & ~32'h0000_0003;
    endfunction
endpackage

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next-PC select: hold, +4 (wraps modulo 2^32) or word-aligned redirect target.
// FETCH_MISALIGN_CHECK_EN adds a flag for redirect targets with nonzero low bits.
module pc_next_sel
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  pc_sel_e         sel,
    input  logic [XLEN-1:0] branch_target,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic            misaligned,
`endif
    output logic [XLEN-1:0] pc_next
);
    always_comb begin
        pc_next = pc;
        case (sel)
            PC_INC:      pc_next = pc + 32'd4;
            PC_REDIRECT: pc_next = align_word(branch_target);
            default:     pc_next = pc;
        endcase
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned = |branch_target[1:0];
`endif
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, imem req/ack fetch, instruction register with valid/ready to decode.
// Optional FETCH_MISALIGN_CHECK_EN: sticky fetch_misaligned flag, misaligned redirects park in IDLE.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] instruction,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] instr_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic            fetch_misaligned,
`endif
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target
);
    fetch_state_e    state, state_next;
    pc_sel_e         pc_sel;
    logic [XLEN-1:0] pc, pc_next, addr_q;
    logic            drop, drop_next, latch, load_addr;
    logic            bad_target, mis_q;

    pc_next_sel u_pc_next_sel (
        .pc            (pc),
        .sel           (pc_sel),
        .branch_target (branch_target),
`ifdef FETCH_MISALIGN_CHECK_EN
        .misaligned    (bad_target),
`endif
        .pc_next       (pc_next)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             mis_q <= 1'b0;
        else if (branch_taken) mis_q <= bad_target;
    end
    assign fetch_misaligned = mis_q;
`else
    assign bad_target = 1'b0;
    assign mis_q      = 1'b0;
`endif

    always_comb begin
        state_next = state;
        drop_next  = drop;
        latch      = 1'b0;
        pc_sel     = PC_HOLD;
        case (state)
            ST_IDLE:  if (!mis_q) state_next = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    if (drop) begin
                        drop_next = 1'b0;
                    end else begin
                        latch      = 1'b1;
                        pc_sel     = PC_INC;
                        state_next = ST_VALID;
                    end
                end
            end
            ST_VALID: if (id_ready) state_next = ST_FETCH;
            default:  state_next = ST_IDLE;
        endcase
        // Redirect wins; an outstanding request must finish on its old address, so mark it stale.
        if (branch_taken) begin
            latch  = 1'b0;
            pc_sel = PC_REDIRECT;
            if (bad_target) begin
                state_next = ST_IDLE;
                drop_next  = 1'b0;
            end else if (state == ST_FETCH && !imem_ack) begin
                state_next = ST_FETCH;
                drop_next  = 1'b1;
            end else begin
                state_next = ST_FETCH;
                drop_next  = 1'b0;
            end
        end
        load_addr = (state_next == ST_FETCH) && ((state != ST_FETCH) || imem_ack);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            addr_q      <= RESET_PC;
            instruction <= NOP_INSTR;
            instr_pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            drop  <= drop_next;
            if (load_addr) addr_q <= pc_next;
            if (latch) begin
                instruction <= imem_rdata;
                instr_pc    <= pc;
            end
        end
    end

    assign imem_req    = (state == ST_FETCH);
    assign imem_addr   = addr_q;
    assign instr_valid = (state == ST_VALID);
    assign opcode      = instruction[6:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: memory responder, directed cases, then random traffic.
module tb_instr_fetch_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic        imem_req, imem_ack = 1'b0, instr_valid, id_ready = 1'b0, branch_taken = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'h0, instruction, instr_pc, branch_target = 32'h0;
    logic [6:0]  opcode;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misaligned;
`endif

    int          errors = 0, checks = 0, delay = 0;
    logic [31:0] exp_q[$];
    logic [31:0] req_log[$];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .id_ready(id_ready), .instruction(instruction), .opcode(opcode), .instr_pc(instr_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_misaligned(fetch_misaligned),
`endif
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_2083;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected presentation order: sequential word addresses from the last redirect/reset.
    function automatic void seed_model(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] t);
        branch_taken  = 1'b1;
        branch_target = t;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (t[1:0] != 2'b00) exp_q.delete();
        else seed_model(t);
`else
        seed_model(t & ~32'h3);
`endif
        step();
        branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        branch_taken = 1'b0;
        seed_model(32'h0);
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 40) begin
            step();
            n++;
        end
        chk("wait_valid", {31'h0, instr_valid}, 32'h1);
    endtask

    task automatic wait_reqs(input int n);
        int c = 0;
        while (req_log.size() < n && c < 60) begin
            step();
            c++;
        end
        chk("req_count", {31'h0, req_log.size() >= n}, 32'h1);
    endtask

    // Memory model: ack after 'delay' wait cycles, data valid with the ack.
    initial begin
        int cnt = 0;
        forever begin
            step();
            if (reset || !imem_req) begin
                imem_ack = 1'b0;
                cnt      = 0;
            end else if (cnt >= delay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                cnt        = 0;
            end else begin
                imem_ack = 1'b0;
                cnt++;
            end
        end
    end

    // Monitor: request log, address stability, and scoreboard on every decode handshake.
    initial begin
        logic        prev_req = 1'b0, prev_ack = 1'b0;
        logic [31:0] prev_addr = 32'h0, e, w;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req = 1'b0;
                prev_ack = 1'b0;
            end else begin
                if (imem_req) begin
                    if (prev_req && !prev_ack) chk("addr_stable", imem_addr, prev_addr);
                    else begin
                        req_log.push_back(imem_addr);
                        chk("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
                    end
                end
                if (instr_valid && id_ready && !branch_taken) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: got pc %h expected no instruction", instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        w = mem_word(e);
                        chk("sb_pc", instr_pc, e);
                        chk("sb_instr", instruction, w);
                        chk("sb_opcode", {25'h0, opcode}, {25'h0, w[6:0]});
                        exp_q.push_back(e + 32'(4 * 64));
                    end
                end
                prev_req  = imem_req;
                prev_ack  = imem_ack;
                prev_addr = imem_addr;
            end
        end
    end

    initial begin
        logic [31:0] old, ins, ipc, t;
        int          n;
        // Reset state and first-fetch latency with zero-wait memory.
        id_ready = 1'b1;
        seed_model(32'h0);
        step();
        step();
        @(negedge clk);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instruction, 32'h0000_0013);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_opcode", {25'h0, opcode}, 32'h13);
        step();
        reset = 1'b0;
        req_log.delete();
        @(negedge clk);
        chk("lat_c1_valid", {31'h0, instr_valid}, 32'h0);
        @(negedge clk);
        chk("lat_c2_valid", {31'h0, instr_valid}, 32'h0);
        chk("lat_c2_req", {31'h0, imem_req}, 32'h1);
        @(negedge clk);
        chk("lat_c3_valid", {31'h0, instr_valid}, 32'h1);
        chk("first_opcode", {25'h0, opcode}, 32'h03);
        chk("first_pc", instr_pc, 32'h0);
        chk("first_instr", instruction, 32'h0000_2083);
        wait_reqs(3);
        chk("seq_addr0", req_log[0], 32'h0);
        chk("seq_addr1", req_log[1], 32'h4);
        chk("seq_addr2", req_log[2], 32'h8);

        // Back-pressure: hold in VALID, then exactly one fetch after id_ready rises.
        id_ready = 1'b0;
        wait_valid();
        ins = instruction;
        ipc = instr_pc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_instr", instruction, ins);
            chk("hold_pc", instr_pc, ipc);
            chk("hold_req", {31'h0, imem_req}, 32'h0);
        end
        step();
        req_log.delete();
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        repeat (6) step();
        chk("one_req_after_ready", 32'(req_log.size()), 32'd1);

        // Redirect during a slow fetch: old address held to ack, stale data dropped.
        delay = 3;
        req_log.delete();
        id_ready = 1'b1;
        step();
        old = imem_addr;
        step();
        redirect(32'h100);
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            chk("stall_addr", imem_addr, old);
            if (imem_ack) break;
            n++;
        end
        wait_reqs(2);
        chk("drop_old_addr", req_log[0], old);
        chk("drop_new_addr", req_log[1], 32'h100);
        wait_valid();
        chk("drop_presented_pc", instr_pc, 32'h100);

        // Redirect in VALID with simultaneous id_ready.
        delay    = 0;
        id_ready = 1'b0;
        wait_valid();
        id_ready = 1'b1;
        redirect(32'h400);
        @(negedge clk);
        chk("rv_valid", {31'h0, instr_valid}, 32'h0);
        chk("rv_req", {31'h0, imem_req}, 32'h1);
        chk("rv_addr", imem_addr, 32'h400);

        // PC wrap at the top of the address space.
        id_ready = 1'b0;
        wait_valid();
        req_log.delete();
        id_ready = 1'b1;
        redirect(32'hFFFF_FFFC);
        wait_reqs(2);
        chk("wrap_a", req_log[0], 32'hFFFF_FFFC);
        chk("wrap_b", req_log[1], 32'h0);

        // Misaligned redirect target.
        id_ready = 1'b0;
        wait_valid();
        req_log.delete();
        id_ready = 1'b1;
        redirect(32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mis_flag", {31'h0, fetch_misaligned}, 32'h1);
            chk("mis_req", {31'h0, imem_req}, 32'h0);
            chk("mis_valid", {31'h0, instr_valid}, 32'h0);
        end
        step();
        req_log.delete();
        redirect(32'h200);
        @(negedge clk);
        chk("mis_clear", {31'h0, fetch_misaligned}, 32'h0);
        wait_reqs(1);
        chk("mis_resume_addr", req_log[0], 32'h200);
`else
        wait_reqs(1);
        chk("mis_zeroed_addr", req_log[0], 32'h100);
`endif

        // Random traffic against the sequential-stream model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 29) == 0) delay = $urandom_range(0, 3);
            id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 24) == 0) begin
                t = $urandom();
                if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
`ifdef FETCH_MISALIGN_CHECK_EN
                if ($urandom_range(0, 2) != 0) t = t & ~32'h3;
`endif
                redirect(t);
            end else begin
                step();
            end
        end
        id_ready = 1'b1;
        repeat (10) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
